// File: rtl/multi_clock_divider.sv
// multi_clock_divider
//   CHANNELS independent programmable clock dividers sharing one system clock.
//   Each channel produces a registered divided clock (period D, high time H),
//   a one-cycle tick on the first cycle of every period, and an active flag.
//   Divisor and high-count are captured into shadow registers only at a
//   period start, so mid-period input changes never glitch the output.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   [CHANNELS]        per-channel run enable
//   sync       in   1-cycle pulse restarting every running channel at count 0
//   divisor    in   [CHANNELS*WIDTH]  period D per channel, ch i at [i*WIDTH +: WIDTH]
//   high_count in   [CHANNELS*WIDTH]  high time H per channel, same packing
//   clk_out    out  [CHANNELS]        registered divided clocks
//   tick       out  [CHANNELS]        registered period-start pulse
//   active     out  [CHANNELS]        channel is running
module multi_clock_divider #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 28
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      sync,
  input  logic [CHANNELS*WIDTH-1:0] divisor,
  input  logic [CHANNELS*WIDTH-1:0] high_count,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       active
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ds;
    logic [WIDTH-1:0] hs;
    logic             clk_r;
    logic             tick_r;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] h_in;
    logic [WIDTH-1:0] cnt_inc;
    logic             last;

    assign d_in    = divisor[g*WIDTH +: WIDTH];
    assign h_in    = high_count[g*WIDTH +: WIDTH];
    // cnt stays <= ds-1 <= 2^WIDTH-2, so the increment cannot wrap.
    assign cnt_inc = cnt + WIDTH'(1);
    assign last    = (cnt == ds - WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= IDLE;
        cnt    <= '0;
        ds     <= '0;
        hs     <= '0;
        clk_r  <= 1'b0;
        tick_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (en[g] && (d_in != '0)) begin
              state  <= RUN;
              ds     <= d_in;
              hs     <= h_in;
              tick_r <= 1'b1;
              clk_r  <= (h_in != '0);
            end else begin
              tick_r <= 1'b0;
              clk_r  <= 1'b0;
            end
          end
          RUN: begin
            if (!en[g]) begin
              // Disable wins over sync and boundary: truncate the period.
              state  <= IDLE;
              cnt    <= '0;
              tick_r <= 1'b0;
              clk_r  <= 1'b0;
            end else if (sync || last) begin
              // Period start: the only place new settings are captured.
              // A zero divisor here parks the channel rather than running
              // with an unreachable terminal count.
              ds  <= d_in;
              hs  <= h_in;
              cnt <= '0;
              if (d_in == '0) begin
                state  <= IDLE;
                tick_r <= 1'b0;
                clk_r  <= 1'b0;
              end else begin
                tick_r <= 1'b1;
                clk_r  <= (h_in != '0);
              end
            end else begin
              cnt    <= cnt_inc;
              tick_r <= 1'b0;
              clk_r  <= (cnt_inc < hs);
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            tick_r <= 1'b0;
            clk_r  <= 1'b0;
          end
        endcase
      end
    end

    assign clk_out[g] = clk_r;
    assign tick[g]    = tick_r;
    assign active[g]  = (state == RUN);
  end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised multi-channel clock divider: successor to the single-channel divider. Each of CHANNELS independent channels produces a registered divided clock with a programmable period and high time, plus a one-cycle period-start tick usable as a clock enable. Divisor/duty changes are glitch-free, taking effect only at a period boundary. A shared sync input phase-aligns all running channels. Sits between the board clock and downstream blocks that need slow clocks or strobes.

## Interface
- CHANNELS, 4, number of independent divider channels (≥1)
- WIDTH, 28, width of each channel's divisor and high-count fields
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  CHANNELS  per-channel run enable
- sync  in  1  single-cycle pulse: restart all running channels at count 0
- divisor  in  CHANNELS*WIDTH  per-channel period D in clk cycles; channel i at [i*WIDTH +: WIDTH]
- high_count  in  CHANNELS*WIDTH  per-channel high time H in clk cycles, same packing
- clk_out  out  CHANNELS  registered divided clocks
- tick  out  CHANNELS  registered one-cycle pulse on first cycle of each period
- active  out  CHANNELS  channel is in RUN

## Operation
- Per channel: state IDLE/RUN, counter cnt[WIDTH-1:0], shadow registers Ds, Hs. Outputs come only from these registers; no combinational path from inputs to outputs.
- Load: Ds <= divisor field, Hs <= high_count field. Loads happen only at the load points below, so mid-period input changes are ignored.
- IDLE: cnt=0, clk_out=0, tick=0, active=0.
  - If en=1 and divisor field ≠0: go to RUN, load, cnt<=0, tick<=1, clk_out<=(high_count field>0).
  - If divisor field =0: stay IDLE.
- RUN, in priority order:
  - en=0: go to IDLE at once. clk_out<=0, tick<=0, cnt<=0. A truncated period is allowed.
  - sync=1: restart as a period start. Load; cnt<=0; tick<=1; clk_out<=(H>0).
  - cnt==Ds-1: period boundary. Load; cnt<=0; tick<=1; clk_out<=(Hnew>0). If the new divisor =0, go to IDLE with outputs 0.
  - Otherwise: cnt<=cnt+1; tick<=0; clk_out<=(cnt+1<Hs).
- Comparisons are unsigned and WIDTH bits wide. cnt never exceeds Ds-1. cnt+1 is computed without overflow because Ds-1 ≤ 2^WIDTH-2.
- Duty corner cases:
  - H=0: clk_out constantly 0.
  - H≥D: clk_out constantly 1.
  - D=1: tick is high every cycle, and clk_out =1 if H≥1.
- Channels are fully independent except that they share sync.
- sync while IDLE has no effect.

## Timing
- Reset (rst_n=0, asynchronous): every channel goes to IDLE. cnt=0, Ds=0, Hs=0, clk_out=0, tick=0, active=0. Release takes effect at the first rising edge with rst_n=1.
- Reset asserted mid-period forces all outputs low immediately, without waiting for a clock edge.
- Enable latency: en sampled high at edge k gives tick=1, active=1, and clk_out=(H>0) after edge k.
- Steady state: clk_out period = Ds cycles, high for the first min(Hs,Ds) cycles of each period. tick repeats every Ds cycles and coincides with the first cycle of clk_out high.
- A divisor or high_count change is visible starting with the period that begins at the next boundary. Latency is at most Ds_old cycles.
- sync sampled at edge k gives tick on every running channel after edge k. After that, channels with equal D stay phase-locked.
- en=0 together with sync or a boundary: en=0 wins, and the channel goes IDLE with no tick.

## Test plan
- Reset and basic divide: D=4, H=2, en=1 on ch0 after reset → clk_out 1100 repeating, tick every 4th cycle aligned with the rising edge; other channels stay 0.
- Odd divide and duty: D=5, H=1 → clk_out 10000 repeating. D=5, H=7 → clk_out constant 1, tick every 5 cycles.
- Glitch-free update: ch1 running at D=8, H=4; change to D=2, H=1 at cnt=3 → remaining 4 cycles are still 0, then 10 repeating from the next boundary.
- Sync alignment: ch0 and ch2 at D=6 with different start times; pulse sync → both tick on the same cycle and every 6 cycles after.
- Disable/zero: drop en mid-period → clk_out=0 and active=0 next cycle. Load divisor=0 at a boundary → channel goes IDLE. D=1, H=1 → tick and clk_out constant 1.
- Async reset mid-operation: assert rst_n=0 between edges while all channels run → all outputs 0 immediately. Release → channels restart with tick at the first edge where en=1.
